th99c_bus_ctrl: RTL and testbench
=================================

TH99C_BUS_CTRL -- requirements
Module: th99c_bus_ctrl

Interface
REQ-001 clock  in  1  single system clock; all state changes on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 CSbar  in  1  chip select, active low.
REQ-004 ALE  in  1  address latch enable, active high.
REQ-005 Rbar / Wbar  in  1 each  read / write strobes, active low.
REQ-006 ABUS  in  8  address high byte.
REQ-007 DBUS_in  in  8  address low byte during the address phase; write data during the data phase.
REQ-008 DBUS_out / DBUS_oe  out  8 / 1  read data and its enable; the tristate buffer lives at chip top.
REQ-009 B0..B6, operand, hour, minute  out  8 each  configuration registers feeding the datapath.
REQ-010 time_load  out  1  one-cycle pulse telling the timekeeper to reload hour/minute.
REQ-011 cfg_valid  out  1  high once B0..B6 and operand have each been written at least once since reset.
REQ-012 err  out  1  sticky flag for rejected accesses.

Function
REQ-013 FSM states SHALL be IDLE, ADDR, WDONE, READ; the FSM sits in IDLE after reset.
REQ-014 IDLE->ADDR SHALL occur when CSbar=0 and ALE=1, latching addr16={ABUS,DBUS_in} on that edge.
REQ-015 In ADDR, CSbar=1 SHALL return the FSM to IDLE with no register effect (abort).
REQ-016 In ADDR with ALE=0, Wbar=0 SHALL write DBUS_in to the addressed register on that edge and go to WDONE.
REQ-017 In ADDR with ALE=0, Wbar=1 and Rbar=0 SHALL go to READ.
REQ-018 If Wbar and Rbar are both low in ADDR, the access SHALL be a write.
REQ-019 In ADDR with ALE=1, the FSM SHALL relatch the address and stay in ADDR.
REQ-020 Address map: 0x0000-0x0006 = B0-B6, 0x0007 = operand, 0x0008 = hour, 0x0009 = minute.
REQ-021 Any other address SHALL be ignored for writes, SHALL return 0x00 on reads, and SHALL set err.
REQ-022 A write of hour > 23 or minute > 59 SHALL be rejected: register unchanged, err set, no time_load.
REQ-023 An accepted write to hour or minute SHALL pulse time_load for exactly one cycle, on the cycle after the write edge.
REQ-024 In READ, DBUS_oe=1 and DBUS_out = addressed register value, registered, 1-cycle latency from READ entry.
REQ-025 READ SHALL last until CSbar=1; then DBUS_oe=0 on the next cycle and the FSM goes to IDLE.
REQ-026 WDONE SHALL return to IDLE on CSbar=1.
REQ-027 WDONE with CSbar=0 and ALE=1 SHALL enter ADDR with the new address latched (back-to-back access).
REQ-028 Only one register SHALL be written per transaction; holding Wbar low in WDONE has no further effect.
REQ-029 cfg_valid SHALL be driven by an 8-bit written mask (B0..B6, operand) and rise on the cycle after the last bit is set.
REQ-030 err SHALL clear only on reset.

Reset
REQ-031 reset SHALL take priority over every other input, including an access in progress.
REQ-032 reset SHALL set: FSM=IDLE, all ten registers=0x00, written mask=0, cfg_valid=0, err=0, time_load=0, DBUS_oe=0, DBUS_out=0x00.
REQ-033 An access interrupted by reset SHALL be discarded; a new access needs a fresh ALE phase.

Structure
REQ-034 Shared package th99c_pkg SHALL hold the register address constants, NUM_CFG_REGS=10, the HOUR_MAX=23 / MIN_MAX=59 limits and the FSM state enum.
REQ-035 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-036 Write B0=13, B1=89, B2=73, B3=59, B4=23, B5=67, B6=1, operand=0xED -> registers hold those values; cfg_valid rises after the operand write.
REQ-037 Write hour=23, then minute=33 -> hour=23, minute=33; two single-cycle time_load pulses; err=0.
REQ-038 Write hour=24, then addr 0x0100=0x55 -> hour unchanged, err=1, no time_load, no register changed.
REQ-039 Read B1 after REQ-036 -> DBUS_oe=1 and DBUS_out=89 one cycle after READ entry; DBUS_oe=0 one cycle after CSbar rises.
REQ-040 Assert reset during the ADDR phase of a write to B3 -> B3=0, FSM=IDLE, all outputs at reset values; the next full write succeeds.
REQ-041 Back-to-back writes without CSbar deasserting (B0=7, then B1=9) -> both registers updated.

Source files
------------

// File: rtl/th99c_pkg.sv
// Shared definitions for the TH99C host bus controller.
//   - Register address map (B0..B6, operand, hour, minute)
//   - Register count, the count covered by the cfg_valid mask, time limits
//   - Bus FSM state encoding
package th99c_pkg;

    localparam int NUM_CFG_REGS  = 10;
    // B0..B6 plus operand must all be written before the datapath config is valid
    localparam int NUM_MASK_BITS = 8;

    localparam logic [15:0] ADDR_B0      = 16'h0000;
    localparam logic [15:0] ADDR_B6      = 16'h0006;
    localparam logic [15:0] ADDR_OPERAND = 16'h0007;
    localparam logic [15:0] ADDR_HOUR    = 16'h0008;
    localparam logic [15:0] ADDR_MINUTE  = 16'h0009;

    localparam logic [7:0] HOUR_MAX = 8'd23;
    localparam logic [7:0] MIN_MAX  = 8'd59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDONE = 2'd2,
        READ  = 2'd3
    } bus_state_t;

    // The map is dense from 0x0000, so a single bound check decodes it
    function automatic logic addr_in_map(input logic [15:0] a);
        return a < 16'(NUM_CFG_REGS);
    endfunction

endpackage

// File: rtl/th99c_bus_ctrl.sv
// TH99C host bus controller: multiplexed address/data slave that owns the
// datapath configuration registers and the timekeeper preset.
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   CSbar, ALE, Rbar, Wbar  bus control (CSbar/Rbar/Wbar active low)
//   ABUS, DBUS_in           address high byte / address low byte or write data
//   DBUS_out, DBUS_oe       registered read data and its output enable
//   B0..B6, operand         datapath configuration registers
//   hour, minute            timekeeper preset registers
//   time_load               one-cycle pulse after an accepted hour/minute write
//   cfg_valid               B0..B6 and operand each written since reset
//   err                     sticky: unmapped access or out-of-range time value
module th99c_bus_ctrl
    import th99c_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       CSbar,
    input  logic       ALE,
    input  logic       Rbar,
    input  logic       Wbar,
    input  logic [7:0] ABUS,
    input  logic [7:0] DBUS_in,
    output logic [7:0] DBUS_out,
    output logic       DBUS_oe,
    output logic [7:0] B0,
    output logic [7:0] B1,
    output logic [7:0] B2,
    output logic [7:0] B3,
    output logic [7:0] B4,
    output logic [7:0] B5,
    output logic [7:0] B6,
    output logic [7:0] operand,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic       time_load,
    output logic       cfg_valid,
    output logic       err
);

    bus_state_t                 state_reg;
    logic [15:0]                addr_reg;
    logic [7:0]                 cfg_reg [0:NUM_CFG_REGS-1];
    logic [NUM_MASK_BITS-1:0]   mask_reg;
    logic                       cfg_valid_reg;
    logic                       err_reg;
    logic                       time_load_reg;
    logic [7:0]                 dout_reg;
    logic                       oe_reg;

    logic [3:0] addr_idx;
    logic       addr_ok;
    logic       value_ok;
    logic       is_time;
    logic       write_cycle;
    logic       write_accept;
    logic       read_enter;
    logic [7:0] rdata;

    assign addr_idx = addr_reg[3:0];
    assign addr_ok  = addr_in_map(addr_reg);
    assign is_time  = (addr_reg == ADDR_HOUR) || (addr_reg == ADDR_MINUTE);

    // Range limits only apply to the timekeeper preset registers
    always_comb begin
        value_ok = 1'b1;
        if (addr_reg == ADDR_HOUR)
            value_ok = (DBUS_in <= HOUR_MAX);
        else if (addr_reg == ADDR_MINUTE)
            value_ok = (DBUS_in <= MIN_MAX);
    end

    // Write wins over read when both strobes are low; ALE relatch wins over both
    assign write_cycle  = (state_reg == ADDR) && !CSbar && !ALE && !Wbar;
    assign read_enter   = (state_reg == ADDR) && !CSbar && !ALE && Wbar && !Rbar;
    assign write_accept = write_cycle && addr_ok && value_ok;

    // Register file: one write per transaction, only from the ADDR state
    generate
        for (genvar gi = 0; gi < NUM_CFG_REGS; gi++) begin : g_cfg
            always_ff @(posedge clock) begin
                if (reset)
                    cfg_reg[gi] <= 8'h00;
                else if (write_accept && (addr_idx == 4'(gi)))
                    cfg_reg[gi] <= DBUS_in;
            end
        end
        for (genvar gi = 0; gi < NUM_MASK_BITS; gi++) begin : g_mask
            always_ff @(posedge clock) begin
                if (reset)
                    mask_reg[gi] <= 1'b0;
                else if (write_accept && (addr_idx == 4'(gi)))
                    mask_reg[gi] <= 1'b1;
            end
        end
    endgenerate

    // Unmapped addresses read back as zero
    always_comb begin
        rdata = 8'h00;
        for (int i = 0; i < NUM_CFG_REGS; i++) begin
            if (addr_ok && (addr_idx == 4'(i)))
                rdata = cfg_reg[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            addr_reg      <= 16'h0000;
            err_reg       <= 1'b0;
            time_load_reg <= 1'b0;
            cfg_valid_reg <= 1'b0;
            dout_reg      <= 8'h00;
            oe_reg        <= 1'b0;
        end else begin
            time_load_reg <= 1'b0;
            cfg_valid_reg <= &mask_reg;
            case (state_reg)
                IDLE: begin
                    if (!CSbar && ALE) begin
                        addr_reg  <= {ABUS, DBUS_in};
                        state_reg <= ADDR;
                    end
                end
                ADDR: begin
                    if (CSbar) begin
                        state_reg <= IDLE;
                    end else if (ALE) begin
                        addr_reg <= {ABUS, DBUS_in};
                    end else if (write_cycle) begin
                        state_reg <= WDONE;
                        if (!(addr_ok && value_ok))
                            err_reg <= 1'b1;
                        else if (is_time)
                            time_load_reg <= 1'b1;
                    end else if (read_enter) begin
                        state_reg <= READ;
                        if (!addr_ok)
                            err_reg <= 1'b1;
                    end
                end
                WDONE: begin
                    if (CSbar) begin
                        state_reg <= IDLE;
                    end else if (ALE) begin
                        addr_reg  <= {ABUS, DBUS_in};
                        state_reg <= ADDR;
                    end
                end
                READ: begin
                    if (CSbar) begin
                        state_reg <= IDLE;
                        oe_reg    <= 1'b0;
                        dout_reg  <= 8'h00;
                    end else begin
                        oe_reg   <= 1'b1;
                        dout_reg <= rdata;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign B0        = cfg_reg[0];
    assign B1        = cfg_reg[1];
    assign B2        = cfg_reg[2];
    assign B3        = cfg_reg[3];
    assign B4        = cfg_reg[4];
    assign B5        = cfg_reg[5];
    assign B6        = cfg_reg[6];
    assign operand   = cfg_reg[7];
    assign hour      = cfg_reg[8];
    assign minute    = cfg_reg[9];
    assign time_load = time_load_reg;
    assign cfg_valid = cfg_valid_reg;
    assign err       = err_reg;
    assign DBUS_out  = dout_reg;
    assign DBUS_oe   = oe_reg;

endmodule

// File: tb/tb_th99c_bus_ctrl.sv
module tb_th99c_bus_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       CSbar = 1'b1;
    logic       ALE   = 1'b0;
    logic       Rbar  = 1'b1;
    logic       Wbar  = 1'b1;
    logic [7:0] ABUS  = 8'h00;
    logic [7:0] DBUS_in = 8'h00;
    logic [7:0] DBUS_out;
    logic       DBUS_oe;
    logic [7:0] B0, B1, B2, B3, B4, B5, B6, operand, hour, minute;
    logic       time_load, cfg_valid, err;

    int total = 0;
    int bad   = 0;

    // reference model and scoreboards
    logic [7:0] exp_reg [0:9];
    logic       exp_err;
    logic [7:0] rd_q [$];
    logic       tl_q [$];

    th99c_bus_ctrl dut (
        .clock(clock), .reset(reset), .CSbar(CSbar), .ALE(ALE), .Rbar(Rbar), .Wbar(Wbar),
        .ABUS(ABUS), .DBUS_in(DBUS_in), .DBUS_out(DBUS_out), .DBUS_oe(DBUS_oe),
        .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6),
        .operand(operand), .hour(hour), .minute(minute),
        .time_load(time_load), .cfg_valid(cfg_valid), .err(err)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0: return B0;
            1: return B1;
            2: return B2;
            3: return B3;
            4: return B4;
            5: return B5;
            6: return B6;
            7: return operand;
            8: return hour;
            default: return minute;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) exp_reg[i] = 8'h00;
        exp_err = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        logic accept;
        logic tl_exp;
        accept = (addr < 16'd10) && !(addr == 16'd8 && data > 8'd23)
                                 && !(addr == 16'd9 && data > 8'd59);
        if (accept) exp_reg[addr[3:0]] = data;
        else        exp_err = 1'b1;
        tl_q.push_back(accept && (addr == 16'd8 || addr == 16'd9));
        @(negedge clock);
        CSbar = 1'b0; ALE = 1'b1; ABUS = addr[15:8]; DBUS_in = addr[7:0];
        @(negedge clock);
        ALE = 1'b0; Wbar = 1'b0; DBUS_in = data;
        @(negedge clock);
        tl_exp = tl_q.pop_front();
        total++;
        if (time_load !== tl_exp) begin
            bad++;
            $display("FAIL wr_time_load addr=%h got=%b exp=%b", addr, time_load, tl_exp);
        end
        Wbar = 1'b1; CSbar = 1'b1;
        @(negedge clock);
        total++;
        if (time_load !== 1'b0) begin
            bad++;
            $display("FAIL wr_time_load_width addr=%h got=%b exp=0", addr, time_load);
        end
        $display("write addr=%h data=%h accept=%b", addr, data, accept);
    endtask

    task automatic bus_read(input logic [15:0] addr);
        logic [7:0] exp_d;
        rd_q.push_back((addr < 16'd10) ? exp_reg[addr[3:0]] : 8'h00);
        if (addr >= 16'd10) exp_err = 1'b1;
        @(negedge clock);
        CSbar = 1'b0; ALE = 1'b1; ABUS = addr[15:8]; DBUS_in = addr[7:0];
        @(negedge clock);
        ALE = 1'b0; Rbar = 1'b0;
        @(negedge clock);   // READ just entered: output not yet valid
        total++;
        if (DBUS_oe !== 1'b0) begin
            bad++;
            $display("FAIL rd_oe_early addr=%h got=%b exp=0", addr, DBUS_oe);
        end
        @(negedge clock);
        exp_d = rd_q.pop_front();
        total++;
        if (DBUS_oe !== 1'b1 || DBUS_out !== exp_d) begin
            bad++;
            $display("FAIL rd_data addr=%h got oe=%b d=%h exp oe=1 d=%h", addr, DBUS_oe, DBUS_out, exp_d);
        end
        CSbar = 1'b1; Rbar = 1'b1;
        @(negedge clock);
        total++;
        if (DBUS_oe !== 1'b0) begin
            bad++;
            $display("FAIL rd_oe_release addr=%h got=%b exp=0", addr, DBUS_oe);
        end
        $display("read addr=%h data=%h", addr, exp_d);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clock);
        total++;
        if ({time_load, cfg_valid, err, DBUS_oe} !== 4'b0000 || DBUS_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got tl=%b cv=%b err=%b oe=%b d=%h exp all 0",
                     time_load, cfg_valid, err, DBUS_oe, DBUS_out);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (dut_reg(i) !== 8'h00) begin
                bad++;
                $display("FAIL reset_reg%0d got=%h exp=00", i, dut_reg(i));
            end
        end
        reset = 1'b0;
        @(negedge clock);
        $display("reset checked");
    endtask

    task automatic test_cfg_write();
        logic [7:0] vals [0:7];
        vals = '{8'd13, 8'd89, 8'd73, 8'd59, 8'd23, 8'd67, 8'd1, 8'hED};
        for (int i = 0; i < 7; i++) bus_write(16'(i), vals[i]);
        total++;
        if (cfg_valid !== 1'b0) begin
            bad++;
            $display("FAIL cfg_valid_early got=%b exp=0", cfg_valid);
        end
        bus_write(16'd7, vals[7]);
        total++;
        if (cfg_valid !== 1'b1) begin
            bad++;
            $display("FAIL cfg_valid_rise got=%b exp=1", cfg_valid);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (dut_reg(i) !== exp_reg[i]) begin
                bad++;
                $display("FAIL cfg_reg%0d got=%h exp=%h", i, dut_reg(i), exp_reg[i]);
            end
        end
    endtask

    task automatic test_time();
        bus_write(16'd8, 8'd23);
        bus_write(16'd9, 8'd33);
        total++;
        if (hour !== 8'd23 || minute !== 8'd33 || err !== 1'b0) begin
            bad++;
            $display("FAIL time_write got h=%0d m=%0d err=%b exp h=23 m=33 err=0", hour, minute, err);
        end
    endtask

    task automatic test_errors();
        bus_write(16'd8, 8'd24);
        bus_write(16'd9, 8'd60);
        bus_write(16'h0100, 8'h55);
        total++;
        if (err !== exp_err) begin
            bad++;
            $display("FAIL err_sticky got=%b exp=%b", err, exp_err);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (dut_reg(i) !== exp_reg[i]) begin
                bad++;
                $display("FAIL err_reg%0d got=%h exp=%h", i, dut_reg(i), exp_reg[i]);
            end
        end
    endtask

    task automatic test_read();
        bus_read(16'd1);
        bus_read(16'd8);
        bus_read(16'd7);
        bus_read(16'h0020);
        total++;
        if (err !== exp_err) begin
            bad++;
            $display("FAIL read_err got=%b exp=%b", err, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        CSbar = 1'b0; ALE = 1'b1; ABUS = 8'h00; DBUS_in = 8'h03;
        @(negedge clock);   // FSM now in ADDR
        reset = 1'b1; ALE = 1'b0; Wbar = 1'b0; DBUS_in = 8'h77;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        // keep the strobe low: without a fresh ALE phase nothing may be written
        @(negedge clock);
        CSbar = 1'b1; Wbar = 1'b1;
        @(negedge clock);
        total++;
        if (B3 !== 8'h00 || {time_load, cfg_valid, err, DBUS_oe} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_mid got B3=%h tl=%b cv=%b err=%b oe=%b exp B3=00 all 0",
                     B3, time_load, cfg_valid, err, DBUS_oe);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (dut_reg(i) !== 8'h00) begin
                bad++;
                $display("FAIL reset_mid_reg%0d got=%h exp=00", i, dut_reg(i));
            end
        end
        bus_write(16'd3, 8'h5A);
        total++;
        if (B3 !== exp_reg[3] || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_rewrite got B3=%h err=%b exp B3=%h err=0", B3, err, exp_reg[3]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        CSbar = 1'b0; ALE = 1'b1; ABUS = 8'h00; DBUS_in = 8'h00;
        @(negedge clock);
        ALE = 1'b0; Wbar = 1'b0; DBUS_in = 8'd7;
        exp_reg[0] = 8'd7;
        @(negedge clock);   // in WDONE: holding Wbar must not write again
        DBUS_in = 8'hFF;
        @(negedge clock);
        Wbar = 1'b1; ALE = 1'b1; DBUS_in = 8'h01;
        @(negedge clock);
        ALE = 1'b0; Wbar = 1'b0; DBUS_in = 8'd9;
        exp_reg[1] = 8'd9;
        @(negedge clock);
        Wbar = 1'b1; CSbar = 1'b1;
        @(negedge clock);
        total++;
        if (B0 !== exp_reg[0] || B1 !== exp_reg[1]) begin
            bad++;
            $display("FAIL back_to_back got B0=%0d B1=%0d exp B0=%0d B1=%0d", B0, B1, exp_reg[0], exp_reg[1]);
        end
        total++;
        if (time_load !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back_flags got tl=%b err=%b exp 0 0", time_load, err);
        end
        $display("back-to-back B0=%0d B1=%0d", B0, B1);
    endtask

    initial begin
        test_reset();
        test_cfg_write();
        test_time();
        test_errors();
        test_read();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
